mips_multicycle_control: RTL

Main control finite-state machine for the multicycle MIPS core. It sequences fetch, decode, execute, memory and writeback over shared datapath resources: one memory port, the register file, the ALU, and the PC/IR/ALUOut registers. Its `ALUOp` output drives `alu_control`. It handles a variable-latency memory port through a `mem_req`/`mem_ready` handshake.

---
 rtl/mips_multicycle_control_pkg.sv | 85 ++++++++
 rtl/mips_multicycle_control.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, ALUOp/select codes,
// opcode/funct values and the packed control-word bundle driven by the decoder.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_REXEC    = 4'd6,
    S_RWB      = 4'd7,
    S_IEXEC    = 4'd8,
    S_IWB      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OPC   = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zext_imm;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_alu_funct(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_SLL, FN_SRL, FN_SRA,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/mem/writeback
// over a shared variable-latency memory port with a mem_req/mem_ready handshake.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       zext_imm,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       illegal_op
);

  state_t r_state;
  state_t w_state_next;
  logic   r_illegal;
  logic   w_illegal_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_illegal_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_illegal_next = 1'b0;
    case (r_state)
      S_FETCH:    if (mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW:                            w_state_next = S_MEMADR;
          OP_RTYPE:                                w_state_next = (funct == FN_JR) ? S_JR : S_REXEC;
          OP_BEQ, OP_BNE:                          w_state_next = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: w_state_next = S_IEXEC;
          OP_J:                                    w_state_next = S_JUMP;
          default: begin
            w_state_next   = S_FETCH;
            w_illegal_next = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op_code == OP_LW)      w_state_next = S_MEMREAD;
        else if (op_code == OP_SW) w_state_next = S_MEMWRITE;
        else                       w_state_next = S_FETCH;
      end
      S_MEMREAD:  if (mem_ready) w_state_next = S_MEMWB;
      S_MEMWRITE: if (mem_ready) w_state_next = S_FETCH;
      S_REXEC: begin
        // funct legality is resolved here so the bad instruction never reaches writeback
        if (is_alu_funct(funct)) begin
          w_state_next = S_RWB;
        end else begin
          w_state_next   = S_FETCH;
          w_illegal_next = 1'b1;
        end
      end
      S_IEXEC:    w_state_next = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JR: w_state_next = S_FETCH;
      default:    w_state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low for the whole reset window, even though the state already reads FETCH.
  always_comb begin
    w_ctrl = '0;
    if (!rst) begin
      w_ctrl.illegal_op = r_illegal;
      case (r_state)
        S_FETCH: begin
          w_ctrl.mem_req   = 1'b1;
          w_ctrl.alu_src_b = SRCB_FOUR;
          w_ctrl.alu_op    = ALUOP_ADD;
          w_ctrl.pc_src    = PCSRC_ALU;
          w_ctrl.ir_write  = mem_ready;
          w_ctrl.pc_en     = mem_ready;
        end
        S_DECODE:   w_ctrl.alu_src_b = SRCB_IMMSH;
        S_MEMADR: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          w_ctrl.mem_req = 1'b1;
          w_ctrl.iord    = 1'b1;
        end
        S_MEMWB: begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWRITE: begin
          w_ctrl.mem_req   = 1'b1;
          w_ctrl.mem_write = 1'b1;
          w_ctrl.iord      = 1'b1;
        end
        S_REXEC: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = SRCB_RT;
          w_ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RWB: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = 1'b1;
        end
        S_IEXEC: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = SRCB_IMM;
          w_ctrl.alu_op    = ALUOP_OPC;
          w_ctrl.zext_imm  = (op_code == OP_ANDI) || (op_code == OP_ORI) || (op_code == OP_XORI);
        end
        S_IWB:      w_ctrl.reg_write = 1'b1;
        S_BRANCH: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = SRCB_RT;
          w_ctrl.alu_op    = ALUOP_SUB;
          w_ctrl.pc_src    = PCSRC_ALUOUT;
          w_ctrl.pc_en     = (op_code == OP_BNE) ? !zero : zero;
        end
        S_JUMP: begin
          w_ctrl.pc_src = PCSRC_JUMP;
          w_ctrl.pc_en  = 1'b1;
        end
        S_JR: begin
          w_ctrl.pc_src = PCSRC_RS;
          w_ctrl.pc_en  = 1'b1;
        end
        default: w_ctrl.illegal_op = r_illegal;
      endcase
    end
  end

  assign mem_req    = w_ctrl.mem_req;
  assign MemWrite   = w_ctrl.mem_write;
  assign IorD       = w_ctrl.iord;
  assign IRWrite    = w_ctrl.ir_write;
  assign RegWrite   = w_ctrl.reg_write;
  assign RegDst     = w_ctrl.reg_dst;
  assign MemtoReg   = w_ctrl.mem_to_reg;
  assign ALUSrcA    = w_ctrl.alu_src_a;
  assign ALUSrcB    = w_ctrl.alu_src_b;
  assign zext_imm   = w_ctrl.zext_imm;
  assign ALUOp      = w_ctrl.alu_op;
  assign PCSrc      = w_ctrl.pc_src;
  assign pc_en      = w_ctrl.pc_en;
  assign illegal_op = w_ctrl.illegal_op;

endmodule
